// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down event/timebase counter.
// Counts modulo MAX_VALUE+1 (wrap) or clamps at 0/MAX_VALUE (saturate).
// It has a synchronous load and clear, and single-cycle overflow and underflow
// pulses that also set a sticky event flag.
// Optional feature macro: COUNTER_COMPARE_EN adds compare_value_i/match_o.
module param_updown_counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_value_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             event_sticky_o
`ifdef COUNTER_COMPARE_EN
  ,
  input  logic [WIDTH-1:0] compare_value_i,
  output logic             match_o
`endif
);

  // Elaboration-time sanity checks on the configuration.
  if (WIDTH < 2) begin : g_width_check
    $error("param_updown_counter: WIDTH must be at least 2");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_reset_check
    $error("param_updown_counter: RESET_VALUE must not exceed MAX_VALUE");
  end

  // All step arithmetic is one bit wider than the count. The extra bit shows
  // that an increment went past the terminal value, or that a decrement
  // borrowed below zero. This holds even when MAX_VALUE is all ones.
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VALUE};
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   count_inc_ext;
  logic [WIDTH:0]   count_dec_ext;
  logic [WIDTH:0]   load_ext;
  logic             up_hits_max;
  logic             down_hits_zero;
  logic [WIDTH-1:0] load_clamped;

  // Widened step results and terminal detection used by the next-state logic.
  always_comb begin
    count_ext      = {1'b0, count_q};
    count_inc_ext  = count_ext + ONE_EXT;
    count_dec_ext  = count_ext - ONE_EXT;
    up_hits_max    = (count_inc_ext > MAX_EXT);
    down_hits_zero = count_dec_ext[WIDTH];
    load_ext       = {1'b0, load_value_i};
    load_clamped   = (load_ext > MAX_EXT) ? MAX_VALUE : load_value_i;
  end

  // Next count, pulses and sticky flag. Clear beats load, and load beats counting.
  always_comb begin
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    sticky_d    = sticky_q;

    if (clear_i) begin
      count_d  = RESET_VALUE;
      sticky_d = 1'b0;
    end else if (load_i) begin
      count_d = load_clamped;
    end else if (enable_i) begin
      if (up_down_i) begin
        if (up_hits_max) begin
          overflow_d = 1'b1;
          sticky_d   = 1'b1;
          count_d    = SATURATE ? MAX_VALUE : '0;
        end else begin
          count_d = count_inc_ext[WIDTH-1:0];
        end
      end else begin
        if (down_hits_zero) begin
          underflow_d = 1'b1;
          sticky_d    = 1'b1;
          count_d     = SATURATE ? '0 : MAX_VALUE;
        end else begin
          count_d = count_dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // Core state register. An active-low synchronous reset restores the reset count and drops every flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= RESET_VALUE;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
    end
  end

`ifdef COUNTER_COMPARE_EN
  logic match_q, match_d;

  // Compare against the count being loaded this edge, so match lines up with count_value_o.
  always_comb begin
    match_d = (count_d == compare_value_i);
  end

  // Match register. At the reset edge it compares the reset count, not the current one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      match_q <= (RESET_VALUE == compare_value_i);
    end else begin
      match_q <= match_d;
    end
  end

  assign match_o = match_q;
`else
  // Without the compare feature there is no comparator and no match register.
`endif

  assign count_value_o  = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;
  assign event_sticky_o = sticky_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed testbench for param_updown_counter (WIDTH=4, MAX_VALUE=9, RESET_VALUE=0).
// A wrapping instance and a saturating instance share one set of inputs.
// Optional feature macro: COUNTER_COMPARE_EN also checks compare_value_i/match_o.
module tb_param_updown_counter;

  logic       clk;
  logic       rst;
  logic       enable_i;
  logic       up_down_i;
  logic       load_i;
  logic [3:0] load_value_i;
  logic       clear_i;
  logic [3:0] compare_value_i;

  logic [3:0] wrap_count, sat_count;
  logic       wrap_ovf, wrap_unf, wrap_stk;
  logic       sat_ovf, sat_unf, sat_stk;
  logic       wrap_match, sat_match;

  int total_checks = 0;
  int bad_checks   = 0;

  param_updown_counter #(
    .WIDTH(4), .MAX_VALUE(4'd9), .RESET_VALUE(4'd0), .SATURATE(1'b0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .enable_i(enable_i), .up_down_i(up_down_i),
    .load_i(load_i), .load_value_i(load_value_i), .clear_i(clear_i),
    .count_value_o(wrap_count), .overflow_o(wrap_ovf), .underflow_o(wrap_unf),
    .event_sticky_o(wrap_stk)
`ifdef COUNTER_COMPARE_EN
    , .compare_value_i(compare_value_i), .match_o(wrap_match)
`endif
  );

  param_updown_counter #(
    .WIDTH(4), .MAX_VALUE(4'd9), .RESET_VALUE(4'd0), .SATURATE(1'b1)
  ) dut_sat (
    .clk(clk), .rst(rst), .enable_i(enable_i), .up_down_i(up_down_i),
    .load_i(load_i), .load_value_i(load_value_i), .clear_i(clear_i),
    .count_value_o(sat_count), .overflow_o(sat_ovf), .underflow_o(sat_unf),
    .event_sticky_o(sat_stk)
`ifdef COUNTER_COMPARE_EN
    , .compare_value_i(compare_value_i), .match_o(sat_match)
`endif
  );

`ifndef COUNTER_COMPARE_EN
  assign wrap_match = 1'b0;
  assign sat_match  = 1'b0;
`endif

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, then waits for the edge and settles 1 unit after it.
  task automatic applyStimulus(input logic r, input logic en, input logic up,
                               input logic ld, input logic [3:0] lv, input logic clr);
    rst          = r;
    enable_i     = en;
    up_down_i    = up;
    load_i       = ld;
    load_value_i = lv;
    clear_i      = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrap(input string tag, input int cnt, input bit ovf, input bit unf, input bit stk);
    checkOutput({tag, ".wrap.cnt"}, 32'(wrap_count), 32'(cnt));
    checkOutput({tag, ".wrap.ovf"}, 32'(wrap_ovf), 32'(ovf));
    checkOutput({tag, ".wrap.unf"}, 32'(wrap_unf), 32'(unf));
    checkOutput({tag, ".wrap.stk"}, 32'(wrap_stk), 32'(stk));
  endtask

  task automatic checkSat(input string tag, input int cnt, input bit ovf, input bit unf, input bit stk);
    checkOutput({tag, ".sat.cnt"}, 32'(sat_count), 32'(cnt));
    checkOutput({tag, ".sat.ovf"}, 32'(sat_ovf), 32'(ovf));
    checkOutput({tag, ".sat.unf"}, 32'(sat_unf), 32'(unf));
    checkOutput({tag, ".sat.stk"}, 32'(sat_stk), 32'(stk));
  endtask

  // Directed sequence with hand-derived expectations.
  initial begin
    int e;
    int es;
    int sat_seq[5];
    sat_seq = '{8, 9, 9, 9, 9};

    rst = 1'b0; enable_i = 1'b0; up_down_i = 1'b1; load_i = 1'b0;
    load_value_i = 4'd0; clear_i = 1'b0; compare_value_i = 4'd0;

    $display("[TB] reset for two cycles");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
`ifdef COUNTER_COMPARE_EN
    checkOutput("rst.match_cmp0", 32'(wrap_match), 32'd1);
`endif
    compare_value_i = 4'd4;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checkWrap("rst", 0, 1'b0, 1'b0, 1'b0);
    checkSat("rst", 0, 1'b0, 1'b0, 1'b0);
`ifdef COUNTER_COMPARE_EN
    checkOutput("rst.match_cmp4", 32'(wrap_match), 32'd0);
`endif

    $display("[TB] count up 12 cycles");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      e  = (i + 1) % 10;
      es = (i + 1 > 9) ? 9 : i + 1;
      checkWrap($sformatf("up%0d", i), e, (i == 9), 1'b0, (i >= 9));
      checkSat($sformatf("up%0d", i), es, (i >= 9), 1'b0, (i >= 9));
`ifdef COUNTER_COMPARE_EN
      checkOutput($sformatf("up%0d.match", i), 32'(wrap_match), 32'(e == 4));
`endif
    end

    $display("[TB] clear then down step from 0");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    checkWrap("clr", 0, 1'b0, 1'b0, 1'b0);
    checkSat("clr", 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkWrap("dn0", 9, 1'b0, 1'b1, 1'b1);
    checkSat("dn0", 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'bx, 1'b0, 4'd0, 1'b0);
      checkWrap($sformatf("hold%0d", i), 9, 1'b0, 1'b0, 1'b1);
      checkSat($sformatf("hold%0d", i), 0, 1'b0, 1'b0, 1'b1);
    end

    $display("[TB] load 7 then count up 5 cycles");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
    checkWrap("ld7", 7, 1'b0, 1'b0, 1'b1);
    checkSat("ld7", 7, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      checkWrap($sformatf("run%0d", k), (8 + k) % 10, (k == 2), 1'b0, 1'b1);
      checkSat($sformatf("run%0d", k), sat_seq[k], (k >= 2), 1'b0, 1'b1);
    end

    $display("[TB] load clamp and load priority over enable");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 1'b0);
    checkWrap("ld14", 9, 1'b0, 1'b0, 1'b1);
    checkSat("ld14", 9, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
    checkWrap("ld3", 3, 1'b0, 1'b0, 1'b1);
    checkSat("ld3", 3, 1'b0, 1'b0, 1'b1);

    $display("[TB] clear beats a wrapping step, reset mid-count");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
    checkWrap("ld9", 9, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    checkWrap("clr9", 0, 1'b0, 1'b0, 1'b0);
    checkSat("clr9", 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkWrap("dn0b", 9, 1'b0, 1'b1, 1'b1);
    checkSat("dn0b", 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    checkWrap("ld5", 5, 1'b0, 1'b0, 1'b1);
    checkSat("ld5", 5, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkWrap("rstmid", 0, 1'b0, 1'b0, 1'b0);
    checkSat("rstmid", 0, 1'b0, 1'b0, 1'b0);

`ifdef COUNTER_COMPARE_EN
    $display("[TB] compare match over two full periods");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      e = (i + 1) % 10;
      checkOutput($sformatf("cmp%0d.cnt", i), 32'(wrap_count), 32'(e));
      checkOutput($sformatf("cmp%0d.match", i), 32'(wrap_match), 32'(e == 4));
    end
`endif

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
